// File: rtl/exec_trace_buffer_if.sv
// exec_trace_buffer_if: valid/ready channel carrying trace entries to the consumer.
interface exec_trace_buffer_if #(parameter int W = 26);
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  modport master(output out_valid, out_data, input out_ready);
  modport slave(input out_valid, out_data, output out_ready);
endinterface

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: captures retired register/memory writes tagged with PC into a FWFT FIFO.
// Define TRACE_OVERWRITE_EN to overwrite the oldest entry on overflow instead of dropping the newest.
module exec_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int PC_W = 8,
  parameter int DATA_W = 16
) (
  input  logic CLK,
  input  logic start,
  input  logic halt,
  input  logic [PC_W-1:0] PC,
  input  logic REG_WRITE,
  input  logic [DATA_W-1:0] regWriteValue,
  input  logic MEM_WRITE,
  input  logic [DATA_W-1:0] memWriteValue,
  exec_trace_buffer_if.master out,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0] drop_count,
  output logic done
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = 2 + PC_W + DATA_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic push, pop, full, ovf, wr, adv;
  always_comb begin
    push = state == RUN && !halt && (REG_WRITE || MEM_WRITE);
    pop = out.out_valid && out.out_ready;
    full = level == (AW+1)'(DEPTH);
    ovf = push && full && !pop;
`ifdef TRACE_OVERWRITE_EN
    wr = push;
    adv = pop || ovf;
`else
    wr = push && !ovf;
    adv = pop;
`endif
    state_nx = state == IDLE ? RUN :
               state == RUN && halt ? DRAIN :
               state == DRAIN && (level == '0 || (level == (AW+1)'(1) && pop)) ? DONE : state;
  end
  assign out.out_valid = level != '0;
  assign out.out_data = mem[head];
  assign done = state == DONE;
  always_ff @(posedge CLK) state <= start ? IDLE : state_nx;
  // kind is {MEM_WRITE, REG_WRITE}; the register value wins when both strobes fire
  always_ff @(posedge CLK)
    if (wr) mem[tail] <= {MEM_WRITE, REG_WRITE, PC, REG_WRITE ? regWriteValue : memWriteValue};
  always_ff @(posedge CLK) begin
    if (start) begin
      head <= '0;
      tail <= '0;
      level <= '0;
      drop_count <= '0;
    end else begin
      if (wr) tail <= tail + AW'(1);
      if (adv) head <= head + AW'(1);
      if (wr && !adv) level <= level + (AW+1)'(1);
      else if (adv && !wr) level <= level - (AW+1)'(1);
      if (ovf && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb_exec_trace_buffer: randomized stimulus checked against a queue-based trace model.
module tb_exec_trace_buffer;
  localparam int DEPTH = 16;
  localparam int PC_W = 8;
  localparam int DATA_W = 16;
  localparam int W = 2 + PC_W + DATA_W;
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} phase_t;
  logic CLK = 0;
  logic start, halt, REG_WRITE, MEM_WRITE;
  logic [PC_W-1:0] PC;
  logic [DATA_W-1:0] regWriteValue, memWriteValue;
  logic [$clog2(DEPTH):0] level;
  logic [7:0] drop_count;
  logic done;
  exec_trace_buffer_if #(.W(W)) bus();
  exec_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .start(start), .halt(halt), .PC(PC),
    .REG_WRITE(REG_WRITE), .regWriteValue(regWriteValue),
    .MEM_WRITE(MEM_WRITE), .memWriteValue(memWriteValue),
    .out(bus), .level(level), .drop_count(drop_count), .done(done)
  );
  always #5 CLK = ~CLK;
  int checks = 0;
  int fails = 0;
  logic [W-1:0] q[$];
  int drops = 0;
  phase_t phase = M_IDLE;
  logic [PC_W-1:0] pc_r = '0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit pr(int p);
    return $urandom_range(99, 0) < p;
  endfunction
  task automatic model_edge();
    bit popped;
    logic [W-1:0] e;
    if (start) begin
      q.delete();
      drops = 0;
      phase = M_IDLE;
      return;
    end
    popped = q.size() != 0 && bus.out_ready;
    if (popped) void'(q.pop_front());
    if (phase == M_RUN && !halt && (REG_WRITE || MEM_WRITE)) begin
      e = {MEM_WRITE, REG_WRITE, PC, REG_WRITE ? regWriteValue : memWriteValue};
      if (q.size() < DEPTH) q.push_back(e);
      else begin
        drops = drops < 255 ? drops + 1 : 255;
`ifdef TRACE_OVERWRITE_EN
        void'(q.pop_front());
        q.push_back(e);
`endif
      end
    end
    case (phase)
      M_IDLE: phase = M_RUN;
      M_RUN: if (halt) phase = M_DRAIN;
      M_DRAIN: if (q.size() == 0) phase = M_DONE;
      default: ;
    endcase
  endtask
  task automatic cyc(bit st, bit hl, bit rw, bit mw, bit rdy);
    start = st;
    halt = hl;
    REG_WRITE = rw;
    MEM_WRITE = mw;
    PC = pc_r;
    regWriteValue = DATA_W'($urandom);
    memWriteValue = DATA_W'($urandom);
    bus.out_ready = rdy;
    pc_r = pc_r + 8'd1;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check("valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("data", 32'(bus.out_data), 32'(q[0]));
    check("level", 32'(level), 32'(q.size()));
    check("drops", 32'(drop_count), 32'(drops));
    check("done", 32'(done), 32'(phase == M_DONE));
  endtask
  task automatic rand_run(int n, int p_st, int p_rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, pr(p_st), pr(p_st), pr(p_rdy));
  endtask
  task automatic halt_and_drain(int p_rdy, int n);
    cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < n; i++) cyc(0, pr(50), pr(50), pr(50), pr(p_rdy));
  endtask
  initial begin
    {start, halt, REG_WRITE, MEM_WRITE} = '0;
    bus.out_ready = 0;
    @(negedge CLK);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 1, 1);
    rand_run(60, 60, 70);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, pr(50), 1);
    for (int i = 0; i < 280; i++) cyc(0, 0, pr(90), pr(50), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1);
    rand_run(150, 50, 50);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, pr(50), 0);
    halt_and_drain(0, 2);
    for (int i = 0; i < 12; i++) cyc(0, 0, pr(50), pr(50), 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);
    halt_and_drain(0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    for (int r = 0; r < 4; r++) begin
      rand_run(40 + r * 10, 70, 30 + r * 15);
      halt_and_drain(40, 60);
      cyc(1, 0, 0, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/exec_trace_buffer.md
Name: exec_trace_buffer

Overview:
Downstream observer of the 10-bit CPU core. It captures every retired register write and memory write, tagging each with its PC, into a FIFO. A consumer (bench monitor or debug UART) drains the FIFO over a valid/ready interface. On halt it drains the remaining entries and then asserts done, so the program's full write history can be checked without probing core internals.

Parameters:
DEPTH, 16, FIFO entries; power of two, range 4..256.
PC_W, 8, PC width.
DATA_W, 16, write-value width.

Ports:
CLK  input  1  clock; all logic on posedge.
start  input  1  synchronous active-high reset; same signal that initialises the core.
halt  input  1  core halt flag.
PC  input  PC_W  PC of the instruction executing this cycle.
REG_WRITE  input  1  core register-write strobe.
regWriteValue  input  DATA_W  register write data.
MEM_WRITE  input  1  core memory-write strobe.
memWriteValue  input  DATA_W  memory write data.
out_valid  output  1  head entry available.
out_ready  input  1  consumer accepts the head entry.
out_data  output  2+PC_W+DATA_W  {kind[1:0], pc, value}.
level  output  clog2(DEPTH)+1  current entry count.
drop_count  output  8  entries lost to overflow; saturates at 255.
done  output  1  trace complete.

Behaviour:
- Reset (start=1 at posedge):
  - state=IDLE; FIFO emptied (pointers 0); level=0; out_valid=0; drop_count=0; done=0.
  - out_data don't-care while out_valid=0.
- States and transitions:
  - IDLE->RUN on the first posedge with start=0. No capture happens in that transition cycle, which matches the core's first fetch.
  - RUN: capture active. RUN->DRAIN on a posedge with halt=1. Events in a halt=1 cycle are not captured.
  - DRAIN: no captures; pops continue. DRAIN->DONE at the posedge where the FIFO becomes or already is empty.
  - DONE: done=1, held until start. Strobes are ignored.
  - start=1 in any state returns to IDLE and flushes, including mid-DRAIN with entries pending.
- Capture (RUN, halt=0, posedge):
  - REG_WRITE only: kind=2'b01, value=regWriteValue.
  - MEM_WRITE only: kind=2'b10, value=memWriteValue.
  - Both strobes: kind=2'b11, value=regWriteValue. One entry only.
  - Neither strobe: nothing pushed.
  - pc = PC sampled at the same edge.
- FIFO:
  - First-word-fall-through; out_valid = !empty.
  - An entry pushed at edge N is visible at out_data after edge N (1-cycle latency).
  - Pop when out_valid & out_ready at the posedge.
- Boundaries:
  - Push and pop in the same cycle: both happen; level unchanged. When full this frees a slot, so the push is accepted with no drop.
  - Push while full with no pop: the new entry is discarded; drop_count+1, saturating at 255. See TRACE_OVERWRITE_EN for the alternative.
  - Pointers wrap modulo DEPTH.
  - Pop on empty: impossible, since out_valid=0.
- level and drop_count are registered and update on the same edge as the push/pop.

Optional Feature:
Macro TRACE_OVERWRITE_EN.
- Defined: a push while full with no pop overwrites the oldest entry. Head and tail both advance; level stays DEPTH; drop_count still increments and saturates. The newest DEPTH events are retained.
- Undefined: drop-newest as described in Behaviour.

Test Plan:
1. Reset, out_ready=1, REG_WRITE at PC 0,1,2 with values 5,6,7 -> out_data {01,00,0005}, {01,01,0006}, {01,02,0007} on consecutive cycles, each one cycle after capture; level never exceeds 1.
2. MEM_WRITE at PC 0x12 with value 0x00AB -> out_data = {2'b10, 8'h12, 16'h00AB}. Both strobes with reg value 0x0003 -> kind 11, value 0x0003.
3. out_ready=0, 20 consecutive REG_WRITEs with values 1..20 (DEPTH=16) -> level=16, drop_count=4. Drain yields values 1..16; with TRACE_OVERWRITE_EN it yields 5..20.
4. FIFO full, out_ready=1, REG_WRITE in the same cycle -> level stays 16, drop_count unchanged, new entry appears at the tail.
5. halt=1 with 5 entries pending and REG_WRITE also high in the halt cycle -> that event is not captured; 5 entries drain; done=1 the cycle after the last pop and stays 1.
6. start=1 during DRAIN with 3 entries pending -> next cycle out_valid=0, level=0, drop_count=0, done=0, state IDLE.
